// File: rtl/mul_hilo_ctrl_if.sv
// rtl/mul_hilo_ctrl_if.sv - command and HI/LO result bundle for the multiply sequencer
interface mul_hilo_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - operand sequencing and HI/LO write-back around a multicycle 32x32 multiplier
module mul_hilo_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_hilo_ctrl_if.slave     cmd,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  output logic               mul_ctrl,
  input  logic [63:0]        mul_prod
);

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        can_accept;
  logic        accept_mul;
  logic        accept_mt;
  logic        calc_last;
  logic        calc_run;

  logic        a_min;
  logic        b_min;
  logic [63:0] sext_a;
  logic [63:0] sext_b;
  logic [63:0] mag;
  logic [63:0] conv;

  // WB behaves like IDLE for command acceptance; only CALC blocks.
  assign can_accept = (state != CALC);
  assign accept_mul = can_accept && cmd.start && !cmd.op[1];
  assign accept_mt  = can_accept && cmd.start &&  cmd.op[1];
  assign calc_run   = (state == CALC) && !cmd.flush;
  assign calc_last  = calc_run && (cnt == CW'(1));

  // The multiplier reports signed products as sign-magnitude and cannot
  // represent 0x80000000, so those operands are handled here directly.
  always_comb begin
    a_min  = (mul_a == 32'h8000_0000);
    b_min  = (mul_b == 32'h8000_0000);
    sext_a = {{32{mul_a[31]}}, mul_a};
    sext_b = {{32{mul_b[31]}}, mul_b};
    mag    = {2'b00, mul_prod[61:0]};
    if (!mul_ctrl) begin
      conv = mul_prod;
    end else if (a_min && b_min) begin
      conv = 64'h4000_0000_0000_0000;
    end else if (a_min) begin
      conv = -(sext_b << 31);
    end else if (b_min) begin
      conv = -(sext_a << 31);
    end else if (mul_prod[63] && (mag != 64'd0)) begin
      conv = -mag;
    end else begin
      conv = mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WB: begin
        state_nxt = accept_mul ? CALC : IDLE;
      end
      CALC: begin
        if (cmd.flush) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(1)) begin
          state_nxt = WB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd.busy = (state == CALC);
    cmd.done = (state == WB);
  end

  // Operands stay frozen outside an accepted multiply so the multicycle path
  // into the multiplier sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= 32'd0;
      mul_b    <= 32'd0;
      mul_ctrl <= 1'b0;
      cnt      <= '0;
    end else if (accept_mul) begin
      mul_a    <= cmd.src_a;
      mul_b    <= cmd.src_b;
      mul_ctrl <= cmd.op[0];
      cnt      <= CW'(LATENCY);
    end else if (calc_run) begin
      cnt      <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (calc_last) begin
      hi_q <= conv[63:32];
      lo_q <= conv[31:0];
    end else if (accept_mt) begin
      if (cmd.op[0]) begin
        lo_q <= cmd.src_a;
      end else begin
        hi_q <= cmd.src_a;
      end
    end
  end

  assign cmd.hi = hi_q;
  assign cmd.lo = lo_q;

endmodule
